// File: rtl/keypad_scan_onehot.sv
// -----------------------------------------------------------------------------
// keypad_scan_onehot
//   Scans a 4x4 active-low matrix keypad and debounces the result. Each row is
//   driven low for SCAN_DIV cycles. The columns are sampled on the last cycle of
//   each row. A full frame is four rows. A code is accepted only after
//   DEBOUNCE_FRAMES consecutive identical frames.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   col_in     [3:0]  keypad columns, active-low, asynchronous to clk
//   row_out    [3:0]  keypad rows, active-low, exactly one bit low
//   onehot     [15:0] debounced key code, bit 4*row+col; 0 = no key
//   key_press         one-cycle pulse when onehot takes a new nonzero value
//   multi_key         last accepted frame saw two or more keys
// -----------------------------------------------------------------------------
module keypad_scan_onehot #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] onehot,
  output logic        key_press,
  output logic        multi_key
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES);

  // Two-flop synchronizer. It idles at all-ones, meaning no key is pressed.
  logic [3:0]    col_meta_reg;
  logic [3:0]    col_sync_reg;

  logic [1:0]    row_idx_reg;
  logic [DW-1:0] dwell_cnt_reg;
  logic [3:0]    row_out_reg;
  logic          frame_end_reg;

  logic [15:0]   candidate_reg;
  logic          cand_multi_reg;
  logic [SW-1:0] stable_cnt_reg;
  logic [15:0]   onehot_reg;
  logic          key_press_reg;
  logic          multi_key_reg;

  logic [15:0]   snapshot;
  logic          sample_now;
  logic          frame_multi;
  logic [15:0]   frame_code;
  logic          frame_match;
  logic [SW-1:0] stable_next;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_reg <= 4'hF;
      col_sync_reg <= 4'hF;
    end else begin
      col_meta_reg <= col_in;
      col_sync_reg <= col_meta_reg;
    end
  end

  assign sample_now = (dwell_cnt_reg == DWELL_LAST);

  // Each row keeps its own nibble of the frame snapshot. A nibble is
  // refreshed once per frame, on the last dwell cycle of its row.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    logic [3:0] snap_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        snap_reg <= '0;
      end else if (sample_now && (row_idx_reg == 2'(gi))) begin
        snap_reg <= ~col_sync_reg;
      end
    end
    assign snapshot[4*gi +: 4] = snap_reg;
  end

  // The candidate is the pair {multi flag, code}. A ghosted frame
  // (code forced to 0, multi set) therefore differs from a true idle frame.
  // It has to debounce like any other code before multi_key reflects it.
  always_comb begin
    frame_multi = ((snapshot & (snapshot - 16'd1)) != 16'd0);
    frame_code  = frame_multi ? 16'd0 : snapshot;
    frame_match = ({frame_multi, frame_code} == {cand_multi_reg, candidate_reg});
    stable_next = SW'(1);
    if (frame_match) begin
      stable_next = (stable_cnt_reg == STABLE_MAX) ? stable_cnt_reg
                                                   : stable_cnt_reg + SW'(1);
    end
    accept = (stable_next == STABLE_MAX) &&
             ({frame_multi, frame_code} != {multi_key_reg, onehot_reg});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx_reg    <= 2'd0;
      dwell_cnt_reg  <= '0;
      row_out_reg    <= 4'b1110;
      frame_end_reg  <= 1'b0;
      candidate_reg  <= 16'd0;
      cand_multi_reg <= 1'b0;
      stable_cnt_reg <= '0;
      onehot_reg     <= 16'd0;
      key_press_reg  <= 1'b0;
      multi_key_reg  <= 1'b0;
    end else begin
      key_press_reg <= 1'b0;

      if (sample_now) begin
        dwell_cnt_reg <= '0;
        row_idx_reg   <= row_idx_reg + 2'd1;
        row_out_reg   <= {row_out_reg[2:0], row_out_reg[3]};
      end else begin
        dwell_cnt_reg <= dwell_cnt_reg + DW'(1);
      end

      // The row-3 sample completes the frame. The snapshot is evaluated on
      // the following cycle, once that last nibble has landed.
      frame_end_reg <= sample_now && (row_idx_reg == 2'd3);

      if (frame_end_reg) begin
        candidate_reg  <= frame_code;
        cand_multi_reg <= frame_multi;
        stable_cnt_reg <= stable_next;
        if (accept) begin
          onehot_reg    <= frame_code;
          multi_key_reg <= frame_multi;
          key_press_reg <= (frame_code != 16'd0);
        end
      end
    end
  end

  assign row_out   = row_out_reg;
  assign onehot    = onehot_reg;
  assign key_press = key_press_reg;
  assign multi_key = multi_key_reg;

endmodule
